// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed BCD seven-segment display.
// Glyphs are active-low, bit0 = segment a through bit6 = segment g.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF   = 4'hF;

  localparam int unsigned NUM_DIGITS = 4;

endpackage

// File: rtl/bcd_scan_display_if.sv
// Display bus: digit capture on one side, scanned segment/anode drive on the other.
// The display block is the slave; whoever feeds digits is the master.
interface bcd_scan_display_if;

  logic [15:0] digits;
  logic        load;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  dig_sel;
  logic        frame_done;

  modport master (
    output digits,
    output load,
    output blank_lz,
    input  seg,
    input  an,
    input  dig_sel,
    input  frame_done
  );

  modport slave (
    input  digits,
    input  load,
    input  blank_lz,
    output seg,
    output an,
    output dig_sel,
    output frame_done
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-decimal codes render as a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit time-multiplexed BCD display driver with frame-synchronous
// digit update, leading-zero blanking and an anode-off ghosting guard.
module bcd_scan_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned GUARD       = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_scan_display_if.slave   bus
);

  localparam logic [15:0] RC_LAST  = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] RC_GUARD = 16'(GUARD);

  logic [15:0] rc_q, rc_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] act_q, act_d;
  logic [15:0] pend_q, pend_d;
  logic        pv_q, pv_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        fd_q, fd_d;

  logic        slot_end;
  logic        boundary;
  logic [3:0]  cur_digit;
  logic [6:0]  glyph;
  logic        lead_zero;

  assign slot_end = (rc_q == RC_LAST);
  assign boundary = slot_end && (sel_q == 2'd3);

  always_comb begin
    rc_d  = slot_end ? 16'd0 : rc_q + 16'd1;
    sel_d = slot_end ? sel_q + 2'd1 : sel_q;
    fd_d  = boundary;
  end

  // Frame-boundary swap keeps one load per frame; a coincident load wins.
  always_comb begin
    act_d  = act_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    if (boundary) begin
      if (bus.load) begin
        act_d = bus.digits;
        pv_d  = 1'b0;
      end else if (pv_q) begin
        act_d = pend_q;
        pv_d  = 1'b0;
      end
    end else if (bus.load) begin
      pend_d = bus.digits;
      pv_d   = 1'b1;
    end
  end

  assign cur_digit = act_q[sel_q*4 +: 4];

  bcd_to_7seg u_dec (
    .bcd_i (cur_digit),
    .seg_o (glyph)
  );

  always_comb begin
    lead_zero = 1'b0;
    unique case (sel_q)
      2'd3:    lead_zero = (act_q[15:12] == 4'd0);
      2'd2:    lead_zero = (act_q[15:8] == 8'd0);
      2'd1:    lead_zero = (act_q[15:4] == 12'd0);
      default: lead_zero = 1'b0;
    endcase
  end

  always_comb begin
    seg_d = (bus.blank_lz && lead_zero) ? SEG_OFF : glyph;
    an_d  = (rc_q < RC_GUARD) ? AN_OFF : ~(4'b0001 << sel_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_q   <= '0;
      sel_q  <= '0;
      act_q  <= '0;
      pend_q <= '0;
      pv_q   <= 1'b0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
      fd_q   <= 1'b0;
    end else begin
      rc_q   <= rc_d;
      sel_q  <= sel_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      fd_q   <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.dig_sel    = sel_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Randomized and directed bench for bcd_scan_display against a
// frame-level reference model (REFRESH_DIV=8, GUARD=2).
module tb_bcd_scan_display;

  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_scan_display_if bus ();

  bcd_scan_display #(
    .REFRESH_DIV (DIV),
    .GUARD       (GRD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [6:0] gly [16];

  int          m_n;
  logic [15:0] m_act;
  logic [15:0] m_pend;
  logic        m_pv;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_fd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  // Enters and leaves on a falling edge; one rising edge per call.
  task automatic step(input logic ld, input logic [15:0] d,
                      input logic bl);
    int rc;
    int sl;
    logic [15:0] upper;
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("an", 32'(bus.an), 32'(e_an));
    chk("dig_sel", 32'(bus.dig_sel), 32'((m_n / DIV) % 4));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    bus.load     = ld;
    bus.digits   = d;
    bus.blank_lz = bl;
    rc    = m_n % DIV;
    sl    = (m_n / DIV) % 4;
    upper = m_act >> (4 * sl);
    e_an  = (rc < GRD) ? 4'hF : ~(4'b0001 << sl);
    e_seg = (bl && sl > 0 && upper == 16'd0) ? 7'h7F : gly[upper[3:0]];
    e_fd  = (m_n % FRAME) == FRAME - 1;
    if (e_fd) begin
      if (ld) begin
        m_act = d;
        m_pv  = 1'b0;
      end else if (m_pv) begin
        m_act = m_pend;
        m_pv  = 1'b0;
      end
    end else if (ld) begin
      m_pend = d;
      m_pv   = 1'b1;
    end
    m_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic bl);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, bl);
  endtask

  // Advance until the next step will run in frame phase ph.
  task automatic run_to(input int ph, input logic bl);
    for (int i = 0; i < FRAME && (m_n % FRAME) != ph; i++)
      step(1'b0, 16'h0, bl);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_n    = 0;
    m_act  = '0;
    m_pend = '0;
    m_pv   = 1'b0;
    e_seg  = 7'h7F;
    e_an   = 4'hF;
    e_fd   = 1'b0;
  endtask

  initial begin
    gly[0] = 7'b1000000; gly[1] = 7'b1111001;
    gly[2] = 7'b0100100; gly[3] = 7'b0110000;
    gly[4] = 7'b0011001; gly[5] = 7'b0010010;
    gly[6] = 7'b0000010; gly[7] = 7'b1111000;
    gly[8] = 7'b0000000; gly[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) gly[i] = 7'b0111111;

    bus.digits   = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b1;

    do_reset();
    idle(40, 1'b1);

    // 1234 without blanking, then spot-check glyphs in the next frame
    run_to(10, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    run_to(3, 1'b0);
    idle(1, 1'b0);
    chk("slot0_is_4", 32'(bus.seg), 32'(7'b0011001));
    run_to(27, 1'b0);
    chk("slot3_is_1", 32'(bus.seg), 32'(7'b1111001));
    idle(80, 1'b0);

    step(1'b1, 16'h0050, 1'b1);
    idle(70, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    idle(70, 1'b1);
    step(1'b1, 16'h12A4, 1'b1);
    idle(70, 1'b1);

    // Two loads in one frame: only the last should ever appear
    run_to(5, 1'b0);
    step(1'b1, 16'h1111, 1'b0);
    run_to(20, 1'b0);
    step(1'b1, 16'h2222, 1'b0);
    idle(50, 1'b0);

    // Load coincident with the frame boundary
    run_to(FRAME - 1, 1'b0);
    step(1'b1, 16'h9876, 1'b0);
    idle(4, 1'b0);
    chk("boundary_load", 32'(bus.seg), 32'(7'b0000010));
    idle(40, 1'b0);

    for (int k = 0; k < 30; k++) begin
      logic [15:0] d;
      logic        bl;
      d  = 16'($urandom);
      if ($urandom_range(0, 1) == 0) d = d & 16'h0F0F;
      if ($urandom_range(0, 3) == 0) d = 16'h0;
      bl = 1'($urandom_range(0, 1));
      idle($urandom_range(1, 40), bl);
      step(1'b1, d, bl);
      if ($urandom_range(0, 2) == 0) step(1'b1, 16'($urandom), bl);
    end
    idle(40, 1'b0);

    // Async reset mid-slot with a pending load outstanding
    step(1'b1, 16'h8888, 1'b0);
    run_to(13, 1'b0);
    step(1'b1, 16'h5555, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_seg", 32'(bus.seg), 32'(7'h7F));
    chk("rst_an", 32'(bus.an), 32'(4'hF));
    chk("rst_fd", 32'(bus.frame_done), 32'(1'b0));
    chk("rst_sel", 32'(bus.dig_sel), 32'(2'd0));
    do_reset();
    idle(70, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
